// File: rtl/urv_writeback.sv
// Writeback stage: result select, load alignment, memory-wait FSM and register-file write port.
// Optional registered forwarding path is enabled by defining URV_WB_BYPASS_EN.
module urv_writeback (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        w_valid_i,
  input  logic        w_load_i,
  input  logic        w_store_i,
  input  logic        w_rd_write_i,
  input  logic [2:0]  w_fun_i,
  input  logic [4:0]  w_rd_i,
  input  logic [1:0]  w_rd_source_i,
  input  logic [31:0] w_dm_addr_i,
  input  logic [31:0] w_rd_value_i,
  input  logic [31:0] w_rd_shifter_i,
  input  logic [31:0] w_rd_multiply_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  input  logic        dm_store_done_i,
  output logic        w_stall_req_o,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_write_o,
  output logic        x_bypass_valid_o,
  output logic [4:0]  x_bypass_rd_o,
  output logic [31:0] x_bypass_value_o
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_LOAD,
    WAIT_STORE
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] result;
  logic [31:0] load_data;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic        unused_addr;

  assign unused_addr = ^w_dm_addr_i[31:2];
  assign rf_rd_o     = w_rd_i;

  always_comb begin
    result = w_rd_value_i;
    case (w_rd_source_i)
      2'b01:   result = w_rd_shifter_i;
      2'b10:   result = w_rd_multiply_i;
      default: result = w_rd_value_i;
    endcase
  end

  always_comb begin
    load_byte = dm_data_l_i[7:0];
    case (w_dm_addr_i[1:0])
      2'b01:   load_byte = dm_data_l_i[15:8];
      2'b10:   load_byte = dm_data_l_i[23:16];
      2'b11:   load_byte = dm_data_l_i[31:24];
      default: load_byte = dm_data_l_i[7:0];
    endcase
    load_half = w_dm_addr_i[1] ? dm_data_l_i[31:16] : dm_data_l_i[15:0];

    load_data = dm_data_l_i;
    case (w_fun_i)
      3'b000:  load_data = {{24{load_byte[7]}}, load_byte};
      3'b100:  load_data = {24'b0, load_byte};
      3'b001:  load_data = {{16{load_half[15]}}, load_half};
      3'b101:  load_data = {16'b0, load_half};
      3'b010:  load_data = dm_data_l_i;
      default: load_data = dm_data_l_i;
    endcase
  end

  assign rf_rd_value_o = w_load_i ? load_data : result;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Stall is raised combinationally so the pipeline freezes in the same cycle the access starts.
  always_comb begin
    state_d       = state_q;
    w_stall_req_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (w_valid_i && w_load_i && !dm_load_done_i) begin
          state_d       = WAIT_LOAD;
          w_stall_req_o = 1'b1;
        end else if (w_valid_i && w_store_i && !dm_store_done_i) begin
          state_d       = WAIT_STORE;
          w_stall_req_o = 1'b1;
        end
      end
      WAIT_LOAD: begin
        if (dm_load_done_i) state_d = IDLE;
        else                w_stall_req_o = 1'b1;
      end
      WAIT_STORE: begin
        if (dm_store_done_i) state_d = IDLE;
        else                 w_stall_req_o = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (!rst_n_i) w_stall_req_o = 1'b0;
  end

  always_comb begin
    rf_rd_write_o = 1'b0;
    if (rst_n_i && w_valid_i && w_rd_write_i && (w_rd_i != 5'd0)) begin
      if (w_load_i)
        rf_rd_write_o = dm_load_done_i && ((state_q == IDLE) || (state_q == WAIT_LOAD));
      else
        rf_rd_write_o = 1'b1;
    end
  end

`ifdef URV_WB_BYPASS_EN
  logic        byp_valid_q;
  logic [4:0]  byp_rd_q, byp_rd_d;
  logic [31:0] byp_value_q, byp_value_d;

  always_comb begin
    byp_rd_d    = byp_rd_q;
    byp_value_d = byp_value_q;
    if (rf_rd_write_o) begin
      byp_rd_d    = rf_rd_o;
      byp_value_d = rf_rd_value_o;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      byp_valid_q <= 1'b0;
      byp_rd_q    <= 5'd0;
      byp_value_q <= 32'd0;
    end else begin
      byp_valid_q <= rf_rd_write_o;
      byp_rd_q    <= byp_rd_d;
      byp_value_q <= byp_value_d;
    end
  end

  assign x_bypass_valid_o = byp_valid_q;
  assign x_bypass_rd_o    = byp_rd_q;
  assign x_bypass_value_o = byp_value_q;
`else
  assign x_bypass_valid_o = 1'b0;
  assign x_bypass_rd_o    = 5'd0;
  assign x_bypass_value_o = 32'd0;
`endif

endmodule

// File: tb/tb_urv_writeback.sv
// Directed self-checking bench for urv_writeback; expected outputs queued per step and popped at check time.
module tb_urv_writeback;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid, isLoad, isStore, rdWrite;
  logic [2:0]  fun;
  logic [4:0]  rd;
  logic [1:0]  rdSource;
  logic [31:0] dmAddr, aluValue, shiftValue, mulValue, dmData;
  logic        loadDone, storeDone;
  logic        stallReq;
  logic [4:0]  rfRd;
  logic [31:0] rfValue;
  logic        rfWrite;
  logic        bypValid;
  logic [4:0]  bypRd;
  logic [31:0] bypValue;

  typedef struct {
    string       tag;
    logic        wr;
    logic [31:0] val;
    logic        stall;
    logic [4:0]  rd;
    logic        rstn;
  } exp_t;

  exp_t expQ[$];

  int checks = 0;
  int failures = 0;

  logic        mBypValid = 1'b0;
  logic [4:0]  mBypRd = 5'd0;
  logic [31:0] mBypValue = 32'd0;

  always #5 clk = ~clk;

  urv_writeback dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .w_valid_i       (valid),
    .w_load_i        (isLoad),
    .w_store_i       (isStore),
    .w_rd_write_i    (rdWrite),
    .w_fun_i         (fun),
    .w_rd_i          (rd),
    .w_rd_source_i   (rdSource),
    .w_dm_addr_i     (dmAddr),
    .w_rd_value_i    (aluValue),
    .w_rd_shifter_i  (shiftValue),
    .w_rd_multiply_i (mulValue),
    .dm_data_l_i     (dmData),
    .dm_load_done_i  (loadDone),
    .dm_store_done_i (storeDone),
    .w_stall_req_o   (stallReq),
    .rf_rd_o         (rfRd),
    .rf_rd_value_o   (rfValue),
    .rf_rd_write_o   (rfWrite),
    .x_bypass_valid_o(bypValid),
    .x_bypass_rd_o   (bypRd),
    .x_bypass_value_o(bypValue)
  );

  task automatic clearInputs();
    rst_n = 1'b1; valid = 1'b0; isLoad = 1'b0; isStore = 1'b0; rdWrite = 1'b0;
    fun = 3'b010; rd = 5'd0; rdSource = 2'b00; dmAddr = 32'd0;
    aluValue = 32'h1111_1111; shiftValue = 32'h2222_2222; mulValue = 32'h3333_3333;
    dmData = 32'd0; loadDone = 1'b0; storeDone = 1'b0;
  endtask

  task automatic pushExp(input string tag, input logic wr, input logic [31:0] val,
                         input logic stall);
    exp_t e;
    e.tag = tag; e.wr = wr; e.val = val; e.stall = stall; e.rd = rd; e.rstn = rst_n;
    expQ.push_back(e);
  endtask

  // Drive one instruction's worth of writeback inputs and record what the port must show.
  task automatic applyStimulus(input string tag, input logic v, input logic ld, input logic st,
                               input logic rw, input logic [2:0] f, input logic [4:0] r,
                               input logic [1:0] src, input logic [31:0] addr,
                               input logic [31:0] dat, input logic ldDone, input logic stDone,
                               input logic expWr, input logic [31:0] expVal,
                               input logic expStall);
    valid = v; isLoad = ld; isStore = st; rdWrite = rw; fun = f; rd = r; rdSource = src;
    dmAddr = addr; dmData = dat; loadDone = ldDone; storeDone = stDone;
    pushExp(tag, expWr, expVal, expStall);
  endtask

  task automatic checkOutput();
    exp_t e;
    if (expQ.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL scoreboard_empty observed=0 expected=1");
      return;
    end
    e = expQ.pop_front();
    checks++;
    assert (rfWrite === e.wr) else begin
      failures++;
      $error("[TB] FAIL %s_write observed=%0b expected=%0b", e.tag, rfWrite, e.wr);
    end
    checks++;
    assert (stallReq === e.stall) else begin
      failures++;
      $error("[TB] FAIL %s_stall observed=%0b expected=%0b", e.tag, stallReq, e.stall);
    end
    checks++;
    assert (rfRd === e.rd) else begin
      failures++;
      $error("[TB] FAIL %s_rd observed=%0d expected=%0d", e.tag, rfRd, e.rd);
    end
    if (e.wr) begin
      checks++;
      assert (rfValue === e.val) else begin
        failures++;
        $error("[TB] FAIL %s_value observed=%h expected=%h", e.tag, rfValue, e.val);
      end
    end
    checks++;
    assert ({bypValid, bypRd, bypValue} === {mBypValid, mBypRd, mBypValue}) else begin
      failures++;
      $error("[TB] FAIL %s_bypass observed=%0b/%0d/%h expected=%0b/%0d/%h", e.tag,
             bypValid, bypRd, bypValue, mBypValid, mBypRd, mBypValue);
    end
    @(posedge clk);
`ifdef URV_WB_BYPASS_EN
    if (!e.rstn) begin
      mBypValid = 1'b0; mBypRd = 5'd0; mBypValue = 32'd0;
    end else begin
      mBypValid = e.wr;
      if (e.wr) begin
        mBypRd = e.rd; mBypValue = e.val;
      end
    end
`endif
    #1;
  endtask

  task automatic step();
    @(negedge clk);
    checkOutput();
  endtask

  initial begin
    clearInputs();
    #1;

    rst_n = 1'b0;
    applyStimulus("rst_alu", 1, 0, 0, 1, 3'b010, 5'd5, 2'b00, 0, 0, 0, 0, 0, 0, 0); step();
    rst_n = 1'b0;
    applyStimulus("rst_load", 1, 1, 0, 1, 3'b010, 5'd5, 2'b00, 0, 0, 0, 0, 0, 0, 0); step();
    clearInputs();

    aluValue = 32'h1234_5678;
    applyStimulus("alu", 1, 0, 0, 1, 3'b010, 5'd5, 2'b00, 0, 0, 0, 0, 1, 32'h1234_5678, 0); step();
    shiftValue = 32'hDEAD_0001;
    applyStimulus("shift", 1, 0, 0, 1, 3'b010, 5'd6, 2'b01, 0, 0, 0, 0, 1, 32'hDEAD_0001, 0); step();
    mulValue = 32'h0BAD_F00D;
    applyStimulus("mul", 1, 0, 0, 1, 3'b010, 5'd9, 2'b10, 0, 0, 0, 0, 1, 32'h0BAD_F00D, 0); step();
    aluValue = 32'h5555_AAAA;
    applyStimulus("src11", 1, 0, 0, 1, 3'b010, 5'd10, 2'b11, 0, 0, 0, 0, 1, 32'h5555_AAAA, 0); step();
    applyStimulus("rd0", 1, 0, 0, 1, 3'b010, 5'd0, 2'b00, 0, 0, 0, 0, 0, 0, 0); step();
    applyStimulus("novalid", 0, 0, 0, 1, 3'b010, 5'd5, 2'b00, 0, 0, 0, 0, 0, 0, 0); step();

    applyStimulus("lb", 1, 1, 0, 1, 3'b000, 5'd8, 2'b00, 32'h0000_1002, 32'h0080_0000, 1, 0,
                  1, 32'hFFFF_FF80, 0); step();
    applyStimulus("lhu", 1, 1, 0, 1, 3'b101, 5'd8, 2'b00, 32'h0000_1002, 32'h8001_0000, 1, 0,
                  1, 32'h0000_8001, 0); step();
    applyStimulus("lh", 1, 1, 0, 1, 3'b001, 5'd8, 2'b00, 32'h0000_1000, 32'h7777_8123, 1, 0,
                  1, 32'hFFFF_8123, 0); step();
    applyStimulus("lbu", 1, 1, 0, 1, 3'b100, 5'd8, 2'b00, 32'h0000_1003, 32'hF000_0000, 1, 0,
                  1, 32'h0000_00F0, 0); step();
    applyStimulus("fun011", 1, 1, 0, 1, 3'b011, 5'd8, 2'b00, 32'h0000_1001, 32'h89AB_CDEF, 1, 0,
                  1, 32'h89AB_CDEF, 0); step();

    for (int i = 0; i < 3; i++) begin
      applyStimulus("slow_lw_wait", 1, 1, 0, 1, 3'b010, 5'd7, 2'b00, 32'h0000_2000, 32'h0, 0, 0,
                    0, 0, 1); step();
    end
    applyStimulus("slow_lw_done", 1, 1, 0, 1, 3'b010, 5'd7, 2'b00, 32'h0000_2000, 32'hCAFE_F00D,
                  1, 0, 1, 32'hCAFE_F00D, 0); step();
    applyStimulus("slow_lw_after", 0, 0, 0, 0, 3'b010, 5'd7, 2'b00, 0, 32'hCAFE_F00D, 0, 0,
                  0, 0, 0); step();

    for (int i = 0; i < 2; i++) begin
      applyStimulus("slow_sw_wait", 1, 0, 1, 0, 3'b010, 5'd4, 2'b00, 0, 0, 0, 0, 0, 0, 1); step();
    end
    applyStimulus("slow_sw_done", 1, 0, 1, 0, 3'b010, 5'd4, 2'b00, 0, 0, 0, 1, 0, 0, 0); step();
    applyStimulus("slow_sw_after", 0, 0, 0, 0, 3'b010, 5'd4, 2'b00, 0, 0, 0, 0, 0, 0, 0); step();

    applyStimulus("stray_done", 1, 0, 0, 0, 3'b010, 5'd4, 2'b00, 0, 0, 1, 1, 0, 0, 0); step();
    applyStimulus("stray_after", 1, 0, 0, 0, 3'b010, 5'd4, 2'b00, 0, 0, 0, 0, 0, 0, 0); step();

    applyStimulus("rstwl_enter", 1, 1, 0, 1, 3'b010, 5'd7, 2'b00, 0, 0, 0, 0, 0, 0, 1); step();
    rst_n = 1'b0;
    applyStimulus("rstwl_reset", 1, 1, 0, 1, 3'b010, 5'd7, 2'b00, 0, 0, 0, 0, 0, 0, 0); step();
    rst_n = 1'b1;
    applyStimulus("rstwl_idle", 1, 0, 0, 0, 3'b010, 5'd7, 2'b00, 0, 0, 0, 0, 0, 0, 0); step();
    applyStimulus("rstwl_done", 1, 0, 0, 0, 3'b010, 5'd7, 2'b00, 0, 32'hCAFE_F00D, 1, 0,
                  0, 0, 0); step();

    aluValue = 32'hA5A5_A5A5;
    applyStimulus("byp_wr3", 1, 0, 0, 1, 3'b010, 5'd3, 2'b00, 0, 0, 0, 0, 1, 32'hA5A5_A5A5, 0); step();
    aluValue = 32'h0F0F_0F0F;
    applyStimulus("byp_wr0", 1, 0, 0, 1, 3'b010, 5'd0, 2'b00, 0, 0, 0, 0, 0, 0, 0); step();
    applyStimulus("byp_hold", 0, 0, 0, 0, 3'b010, 5'd0, 2'b00, 0, 0, 0, 0, 0, 0, 0); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
